// File: rtl/nco_phase_recover_if.sv
// nco_phase_recover_if: sample-in / phase-out bundle between a sample source and the phase recovery core.
interface nco_phase_recover_if #(
  parameter int DATA_W  = 14,
  parameter int PHASE_W = 32
);
  logic                      in_valid;
  logic                      in_ready;
  logic signed [DATA_W-1:0]  sin_i;
  logic signed [DATA_W-1:0]  cos_i;
  logic                      out_valid;
  logic [PHASE_W-1:0]        phase_o;
  logic [PHASE_W-1:0]        phi_inc_o;
  logic                      freq_valid_o;
  logic [DATA_W+1:0]         mag_o;
  modport master (
    output in_valid, sin_i, cos_i,
    input  in_ready, out_valid, phase_o, phi_inc_o, freq_valid_o, mag_o
  );
  modport slave (
    input  in_valid, sin_i, cos_i,
    output in_ready, out_valid, phase_o, phi_inc_o, freq_valid_o, mag_o
  );
endinterface

// File: rtl/nco_phase_recover.sv
// nco_phase_recover: vectoring CORDIC that turns sin/cos pairs back into phase, phase increment and magnitude.
module nco_phase_recover #(
  parameter int DATA_W  = 14,
  parameter int PHASE_W = 32,
  parameter int ITER    = 16
) (
  input logic clk,
  input logic reset,
  input logic clken,
  nco_phase_recover_if.slave bus
);
  localparam int W  = DATA_W + 6;
  localparam int IW = $clog2(ITER);
  typedef enum logic [1:0] {IDLE, PREROT, ROT, DONE} state_t;
  function automatic logic [PHASE_W-1:0] atan_val(input int n);
    return PHASE_W'(longint'($atan(2.0 ** (-n)) / (2.0 * 3.14159265358979323846) * (2.0 ** PHASE_W)));
  endfunction
  logic [PHASE_W-1:0] atan_tab [ITER];
  for (genvar k = 0; k < ITER; k++) begin : g_atan
    localparam logic [PHASE_W-1:0] A = atan_val(k);
    assign atan_tab[k] = A;
  end
  state_t              state_q, state_d;
  logic signed [W-1:0] x_q, x_d, y_q, y_d, xs, ys;
  logic [PHASE_W-1:0]  z_q, z_d, prev_q, prev_d, phase_q, phase_d, phi_q, phi_d;
  logic [IW-1:0]       i_q, i_d;
  logic [DATA_W+1:0]   mag_q, mag_d;
  logic [W-1:0]        rnd;
  logic                seen_q, seen_d, ov_q, ov_d, fv_q, fv_d, neg, dir;
  assign xs  = x_q >>> i_q;
  assign ys  = y_q >>> i_q;
  assign neg = x_q[W-1];
  assign dir = ~y_q[W-1];
  assign rnd = x_q + W'(8);
  assign bus.in_ready     = state_q == IDLE;
  assign bus.out_valid    = ov_q;
  assign bus.phase_o      = phase_q;
  assign bus.phi_inc_o    = phi_q;
  assign bus.freq_valid_o = fv_q;
  assign bus.mag_o        = mag_q;
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    i_d     = i_q;
    prev_d  = prev_q;
    seen_d  = seen_q;
    ov_d    = 1'b0;
    phase_d = phase_q;
    phi_d   = phi_q;
    fv_d    = fv_q;
    mag_d   = mag_q;
    case (state_q)
      IDLE: if (bus.in_valid) begin
        x_d     = {{2{bus.cos_i[DATA_W-1]}}, bus.cos_i, 4'b0};
        y_d     = {{2{bus.sin_i[DATA_W-1]}}, bus.sin_i, 4'b0};
        state_d = PREROT;
      end
      PREROT: begin
        x_d     = neg ? -x_q : x_q;
        y_d     = neg ? -y_q : y_q;
        z_d     = {neg, {(PHASE_W-1){1'b0}}};
        i_d     = '0;
        state_d = ROT;
      end
      ROT: begin
        x_d     = dir ? x_q + ys : x_q - ys;
        y_d     = dir ? y_q - xs : y_q + xs;
        // a zero vector never rotates, so keep its angle at the pre-rotation value
        z_d     = (x_q == '0 && y_q == '0) ? z_q : dir ? z_q + atan_tab[i_q] : z_q - atan_tab[i_q];
        i_d     = i_q + 1'b1;
        state_d = i_q == IW'(ITER - 1) ? DONE : ROT;
      end
      default: begin
        ov_d    = 1'b1;
        phase_d = z_q;
        phi_d   = seen_q ? z_q - prev_q : '0;
        fv_d    = seen_q;
        seen_d  = 1'b1;
        prev_d  = z_q;
        mag_d   = rnd[W-1:4];
        state_d = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      i_q     <= '0;
      prev_q  <= '0;
      seen_q  <= 1'b0;
      ov_q    <= 1'b0;
      phase_q <= '0;
      phi_q   <= '0;
      fv_q    <= 1'b0;
      mag_q   <= '0;
    end else if (clken) begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      i_q     <= i_d;
      prev_q  <= prev_d;
      seen_q  <= seen_d;
      ov_q    <= ov_d;
      phase_q <= phase_d;
      phi_q   <= phi_d;
      fv_q    <= fv_d;
      mag_q   <= mag_d;
    end
endmodule
